// File: rtl/quad_encoder_array.sv
// quad_encoder_array
// Multi-channel quadrature encoder front end. Every channel synchronises and
// glitch-filters its A/B pins, decodes quadrature steps into a wrapping signed
// position, flags illegal (double-bit) transitions and reports the number of
// steps seen in each fixed-length velocity window.
module quad_encoder_array #(
  parameter int CHANNELS      = 2,
  parameter int COUNT_WIDTH   = 24,
  parameter int FILTER_CYCLES = 100,
  parameter int VEL_WINDOW    = 32000
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [CHANNELS-1:0]             i_quadA,
  input  logic [CHANNELS-1:0]             i_quadB,
  input  logic [CHANNELS-1:0]             i_zero,
  input  logic                            i_errorClear,
  output logic [CHANNELS*COUNT_WIDTH-1:0] o_count,
  output logic [CHANNELS*COUNT_WIDTH-1:0] o_velocity,
  output logic                            o_velValid,
  output logic [CHANNELS-1:0]             o_error
);

  // Filter stability counter: one value is accepted after FILTER_CYCLES
  // consecutive mismatching samples, so the counter only needs to reach
  // FILTER_CYCLES-1 before the update fires.
  localparam int                FILT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

  // Startup hold covers the filter settling time plus the synchroniser and
  // decoder pipeline, so a static encoder that disagrees with the all-zero
  // reset state does not produce a bogus step or error.
  localparam int                HOLD_CYCLES = FILTER_CYCLES + 4;
  localparam int                HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE   = HOLD_W'(HOLD_CYCLES);

  // Shared velocity window counter runs 0..VEL_WINDOW-1.
  localparam int               WIN_W    = $clog2(VEL_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);

  logic [HOLD_W-1:0] r_startCnt;
  logic              w_hold;
  logic [WIN_W-1:0]  r_winCnt;
  logic              w_winLast;
  logic              r_velValid;

  assign w_hold    = (r_startCnt != HOLD_DONE);
  assign w_winLast = (r_winCnt == WIN_LAST);

  // Count the startup hold cycles after reset release, then park at the end.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_startCnt <= '0;
    end else if (w_hold) begin
      r_startCnt <= r_startCnt + HOLD_W'(1);
    end
  end

  // Free-running velocity window; the terminal cycle raises a one-cycle valid.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_winCnt   <= '0;
      r_velValid <= 1'b0;
    end else begin
      r_velValid <= w_winLast;
      if (w_winLast) begin
        r_winCnt <= '0;
      end else begin
        r_winCnt <= r_winCnt + WIN_W'(1);
      end
    end
  end

  assign o_velValid = r_velValid;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gen_ch
    // Bit 1 carries A, bit 0 carries B throughout the channel.
    logic [1:0]                    w_raw;
    logic [1:0]                    r_sync1;
    logic [1:0]                    r_sync2;
    logic [1:0]                    r_filt;
    logic [FILT_W-1:0]             r_stable [2];
    logic [1:0]                    r_prev;
    logic signed [1:0]             w_step;
    logic                          w_illegal;
    logic signed [COUNT_WIDTH-1:0] r_count;
    logic signed [COUNT_WIDTH-1:0] r_acc;
    logic signed [COUNT_WIDTH-1:0] r_vel;
    logic signed [COUNT_WIDTH:0]   w_accSum;
    logic signed [COUNT_WIDTH-1:0] w_accSat;
    logic                          r_err;

    assign w_raw = {i_quadA[ch], i_quadB[ch]};

    // Two-flop synchroniser on both raw encoder pins.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_sync1 <= 2'b00;
        r_sync2 <= 2'b00;
      end else begin
        r_sync1 <= w_raw;
        r_sync2 <= r_sync1;
      end
    end

    // Glitch filter: a synced value must disagree with the filtered value for
    // FILTER_CYCLES consecutive cycles before it is accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_filt <= 2'b00;
        for (int k = 0; k < 2; k++) begin
          r_stable[k] <= '0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (r_sync2[k] == r_filt[k]) begin
            r_stable[k] <= '0;
          end else if (r_stable[k] == FILT_LAST) begin
            r_filt[k]   <= r_sync2[k];
            r_stable[k] <= '0;
          end else begin
            r_stable[k] <= r_stable[k] + FILT_W'(1);
          end
        end
      end
    end

    // Remember last cycle's filtered state for the transition decoder.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_prev <= 2'b00;
      end else begin
        r_prev <= r_filt;
      end
    end

    // Decode previous->current {A,B}; A leading B is a forward step, and a
    // double-bit change is illegal. Everything is muted during startup hold.
    always_comb begin
      w_step    = 2'sb00;
      w_illegal = 1'b0;
      case ({r_prev, r_filt})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: w_step = 2'sb01;
        4'b1000, 4'b1110, 4'b0111, 4'b0001: w_step = 2'sb11;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;
        default: begin
        end
      endcase
      if (w_hold) begin
        w_step    = 2'sb00;
        w_illegal = 1'b0;
      end
    end

    // Position count wraps naturally; a zero request beats a same-cycle step.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_count <= '0;
      end else if (i_zero[ch]) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + COUNT_WIDTH'(w_step);
      end
    end

    // Accumulator plus step, clamped to the signed limits instead of wrapping
    // so a runaway window reports full scale rather than a sign flip.
    always_comb begin
      w_accSum = (COUNT_WIDTH + 1)'(r_acc) + (COUNT_WIDTH + 1)'(w_step);
      w_accSat = w_accSum[COUNT_WIDTH-1:0];
      if (w_accSum[COUNT_WIDTH] != w_accSum[COUNT_WIDTH-1]) begin
        if (w_accSum[COUNT_WIDTH]) begin
          w_accSat = {1'b1, {(COUNT_WIDTH - 1){1'b0}}};
        end else begin
          w_accSat = {1'b0, {(COUNT_WIDTH - 1){1'b1}}};
        end
      end
    end

    // Accumulate steps across the window and publish them on the terminal cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_acc <= '0;
        r_vel <= '0;
      end else if (w_winLast) begin
        r_vel <= w_accSat;
        r_acc <= '0;
      end else begin
        r_acc <= w_accSat;
      end
    end

    // Sticky illegal-transition flag; a new error beats a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_err <= 1'b0;
      end else if (w_illegal) begin
        r_err <= 1'b1;
      end else if (i_errorClear) begin
        r_err <= 1'b0;
      end
    end

    assign o_count[ch*COUNT_WIDTH +: COUNT_WIDTH]    = r_count;
    assign o_velocity[ch*COUNT_WIDTH +: COUNT_WIDTH] = r_vel;
    assign o_error[ch]                               = r_err;
  end

endmodule
